unidade_controle_desafio: RTL and testbench
===========================================

Name: unidade_controle_desafio

Overview:
- Moore FSM that sequences the memory-game datapath: address counter, play register, ROM comparator, edge detector and 3000-cycle timeout counter.
- It clears the datapath and then, for each ROM position, waits for a play. It registers the play, compares it with the ROM and either advances the counter or ends the round.
- A round ends as hit (all 16 positions matched), miss (mismatch) or timeout (no play before the datapath timeout).
- Sits beside the datapath inside the challenge top level; all datapath control strobes come from this block.

Parameters:
- TIMEOUT_EN, 1, when 0 the timeout input is ignored and espera_jogada waits indefinitely.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 forces state inicial immediately.
- iniciar  input  1  level; starts or restarts a round.
- jogada_feita  input  1  one-cycle pulse from the datapath edge detector.
- igual  input  1  comparator result, ROM data equals registered play.
- fimC  input  1  address counter rco (counter at 15).
- timeout  input  1  datapath timeout flag; stays high until the timeout counter is cleared.
- zeraC  output  1  clears address counter, timeout counter and edge detector.
- contaC  output  1  increments address counter; also clears timeout counter.
- zeraR  output  1  clears play register.
- registraR  output  1  loads play register from switches.
- pronto  output  1  round finished; freezes the datapath timeout counter.
- acertou  output  1  round ended with all 16 plays correct.
- errou  output  1  round ended on a wrong play.
- deu_timeout  output  1  round ended by timeout.
- db_estado  output  4  current state code, for the 7-segment debug display.

Behaviour:
- Moore machine. Outputs are decoded only from the state register, so they are valid in the same cycle the state is entered. Each strobe lasts exactly one cycle per state visit. One state register, 4 bits.
- On reset = 0: state = inicial (0x0) asynchronously. All outputs are 0 and db_estado = 0x0.

States (code: asserted outputs -> transition evaluated at the next rising edge):
- inicial (0x0): none -> preparacao if iniciar = 1, else stay.
- preparacao (0x1): zeraC, zeraR -> espera_jogada unconditionally.
- espera_jogada (0x2): none -> registra if jogada_feita = 1; else fim_timeout if timeout = 1 and TIMEOUT_EN = 1; else stay. If jogada_feita and timeout are high in the same cycle, jogada_feita wins.
- registra (0x4): registraR -> comparacao.
- comparacao (0x5): none -> errou if igual = 0; else acertou if fimC = 1; else proximo. igual is sampled here, one cycle after registraR, so the register output is stable.
- proximo (0x6): contaC -> espera_jogada.
- acertou (0xA): pronto, acertou -> preparacao if iniciar = 1, else stay.
- errou (0xE): pronto, errou -> preparacao if iniciar = 1, else stay.
- fim_timeout (0xD): pronto, deu_timeout -> preparacao if iniciar = 1, else stay.
- Unused codes (0x3, 0x7–0x9, 0xB, 0xC, 0xF): all outputs 0, next state inicial.

Timing and boundary rules:
- Minimum latency from jogada_feita in espera_jogada to contaC is 3 cycles: registra, comparacao, proximo.
- A correct play at address 15 (fimC = 1 in comparacao) goes to acertou, never proximo, so the counter does not wrap.
- iniciar held high in a final state restarts the round. Holding it permanently loops preparacao -> espera_jogada without error.
- iniciar is ignored in every non-final state except inicial.
- jogada_feita pulses arriving outside espera_jogada are ignored, not queued.
- Reset asserted mid-round returns to inicial within the same cycle. The datapath is cleared only on the next pass through preparacao.
- At most one of acertou, errou and deu_timeout is high at any time. pronto = acertou | errou | deu_timeout.

Test Plan:
- Reset low 2 cycles, then high; iniciar = 0 for 5 cycles -> db_estado = 0x0, all outputs 0. Pulse iniciar -> next cycle db_estado = 0x1 with zeraC = zeraR = 1, then 0x2.
- Sixteen plays, each a jogada_feita pulse with igual = 1; fimC = 1 only on the 16th -> 16 registraR pulses and 15 contaC pulses. End state acertou (0xA) with pronto = acertou = 1.
- Third play with igual = 0 -> comparacao then errou (0xE), with contaC pulsed exactly 2 times in the round.
- In espera_jogada, raise timeout = 1 with no jogada_feita -> fim_timeout (0xD), pronto = deu_timeout = 1. Repeat with TIMEOUT_EN = 0 -> stays in 0x2.
- jogada_feita and timeout high in the same cycle in espera_jogada -> registra (0x4), not 0xD.
- Reset pulled low while in registra -> db_estado = 0x0 before the next clock edge. iniciar in errou -> preparacao, then a new round starts.

Source files
------------

// File: rtl/unidade_controle_desafio.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle_desafio
// Brief    : Moore FSM sequencing the memory-game datapath (clear, wait play,
//            register, compare, advance) and reporting hit/miss/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle_desafio #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    input  logic       timeout,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       deu_timeout,
    output logic [3:0] db_estado
);

    localparam logic [3:0] c_INICIAL     = 4'h0;
    localparam logic [3:0] c_PREPARACAO  = 4'h1;
    localparam logic [3:0] c_ESPERA      = 4'h2;
    localparam logic [3:0] c_REGISTRA    = 4'h4;
    localparam logic [3:0] c_COMPARACAO  = 4'h5;
    localparam logic [3:0] c_PROXIMO     = 4'h6;
    localparam logic [3:0] c_ACERTOU     = 4'hA;
    localparam logic [3:0] c_FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] c_ERROU       = 4'hE;

    logic [3:0] estado_q;
    logic [3:0] estado_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= c_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = c_INICIAL;
        case (estado_q)
            c_INICIAL:     estado_d = iniciar ? c_PREPARACAO : c_INICIAL;
            c_PREPARACAO:  estado_d = c_ESPERA;
            // A play arriving together with the timeout flag still counts.
            c_ESPERA: begin
                if (jogada_feita) begin
                    estado_d = c_REGISTRA;
                end else if (timeout && TIMEOUT_EN) begin
                    estado_d = c_FIM_TIMEOUT;
                end else begin
                    estado_d = c_ESPERA;
                end
            end
            c_REGISTRA:    estado_d = c_COMPARACAO;
            c_COMPARACAO: begin
                if (!igual) begin
                    estado_d = c_ERROU;
                end else if (fimC) begin
                    estado_d = c_ACERTOU;
                end else begin
                    estado_d = c_PROXIMO;
                end
            end
            c_PROXIMO:     estado_d = c_ESPERA;
            c_ACERTOU,
            c_ERROU,
            c_FIM_TIMEOUT: estado_d = iniciar ? c_PREPARACAO : estado_q;
            default:       estado_d = c_INICIAL;
        endcase
    end

    always_comb begin
        zeraC       = 1'b0;
        contaC      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        deu_timeout = 1'b0;
        case (estado_q)
            c_PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            c_REGISTRA:    registraR   = 1'b1;
            c_PROXIMO:     contaC      = 1'b1;
            c_ACERTOU:     acertou     = 1'b1;
            c_ERROU:       errou       = 1'b1;
            c_FIM_TIMEOUT: deu_timeout = 1'b1;
            default: ;
        endcase
    end

    assign pronto    = acertou | errou | deu_timeout;
    assign db_estado = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_desafio.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_controle_desafio
// Brief    : Vector/scoreboard bench; one DUT with timeout enabled, one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_desafio;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, jogada_feita = 1'b0, igual = 1'b0, fimC = 1'b0, timeout = 1'b0;
    logic [7:0] outs_a, outs_b;
    logic [3:0] st_a, st_b;
    logic       pr_a, pr_b;

    always #5 clock = ~clock;

    unidade_controle_desafio #(.TIMEOUT_EN(1'b1)) u_dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .timeout(timeout),
        .zeraC(outs_a[7]), .contaC(outs_a[6]), .zeraR(outs_a[5]), .registraR(outs_a[4]),
        .pronto(pr_a), .acertou(outs_a[2]), .errou(outs_a[1]), .deu_timeout(outs_a[0]),
        .db_estado(st_a)
    );

    unidade_controle_desafio #(.TIMEOUT_EN(1'b0)) u_dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .timeout(timeout),
        .zeraC(outs_b[7]), .contaC(outs_b[6]), .zeraR(outs_b[5]), .registraR(outs_b[4]),
        .pronto(pr_b), .acertou(outs_b[2]), .errou(outs_b[1]), .deu_timeout(outs_b[0]),
        .db_estado(st_b)
    );

    assign outs_a[3] = pr_a;
    assign outs_b[3] = pr_b;

    typedef struct {
        logic       ini, jog, ig, fim, to;
        logic [3:0] st, st_nt;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] st_nt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   n_reg  = 0;
    int   n_cnt  = 0;

    // Expected strobes {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,deu_timeout}.
    function automatic logic [7:0] exp_outs(input logic [3:0] st);
        case (st)
            4'h1:    return 8'b1010_0000;
            4'h4:    return 8'b0001_0000;
            4'h6:    return 8'b0100_0000;
            4'hA:    return 8'b0000_1100;
            4'hE:    return 8'b0000_1010;
            4'hD:    return 8'b0000_1001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic check_dut(input string tag, input logic [3:0] st, input logic [7:0] o,
                             input logic [3:0] exp_st);
        checks++;
        if ({st, o} !== {exp_st, exp_outs(exp_st)}) begin
            errors++;
            $display("FAIL %s: got state=%h outs=%b, required state=%h outs=%b",
                     tag, st, o, exp_st, exp_outs(exp_st));
        end
    endtask

    task automatic step(input logic ini, jog, ig, fim, to,
                        input logic [3:0] st, st_nt, input string tag);
        exp_t e;
        @(negedge clock);
        iniciar = ini; jogada_feita = jog; igual = ig; fimC = fim; timeout = to;
        sb.push_back({st, st_nt});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_dut({tag, "_en"}, st_a, outs_a, e.st);
        check_dut({tag, "_nt"}, st_b, outs_b, e.st_nt);
        if (outs_a[4]) n_reg++;
        if (outs_a[6]) n_cnt++;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i])
            step(tbl[i].ini, tbl[i].jog, tbl[i].ig, tbl[i].fim, tbl[i].to,
                 tbl[i].st, tbl[i].st_nt, tag);
        tbl.delete();
    endtask

    task automatic add(input logic ini, jog, ig, fim, to, input logic [3:0] st, st_nt);
        vec_t v;
        v.ini = ini; v.jog = jog; v.ig = ig; v.fim = fim; v.to = to; v.st = st; v.st_nt = st_nt;
        tbl.push_back(v);
    endtask

    // One play from espera_jogada; final is the state reached after comparacao.
    task automatic play(input logic ig, fim, input logic [3:0] final_st);
        step(0, 1, 0, 0, 0, 4'h4, 4'h4, "registra");
        step(0, 0, 0, 0, 0, 4'h5, 4'h5, "comparacao");
        step(0, 0, ig, fim, 0, final_st, final_st, "resolve");
        if (final_st == 4'h6) step(0, 0, 0, 0, 0, 4'h2, 4'h2, "proximo");
    endtask

    task automatic check_count(input string tag, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d pulses, required %0d", tag, got, req);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_dut("reset_en", st_a, outs_a, 4'h0);
        check_dut("reset_nt", st_b, outs_b, 4'h0);
        reset = 1'b1;

        // Idle, then start.
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 4'h0, 4'h0);
        add(1, 0, 0, 0, 0, 4'h1, 4'h1);
        add(0, 0, 0, 0, 0, 4'h2, 4'h2);
        run_table("start");

        // Sixteen correct plays.
        n_reg = 0; n_cnt = 0;
        for (int k = 0; k < 16; k++)
            play(1'b1, (k == 15), (k == 15) ? 4'hA : 4'h6);
        step(0, 0, 0, 0, 0, 4'hA, 4'hA, "hold_acertou");
        check_count("registraR_16", n_reg, 16);
        check_count("contaC_15", n_cnt, 15);

        // Restart, miss on third play.
        add(1, 0, 0, 0, 0, 4'h1, 4'h1);
        add(0, 0, 0, 0, 0, 4'h2, 4'h2);
        run_table("restart1");
        n_cnt = 0;
        play(1'b1, 1'b0, 4'h6);
        play(1'b1, 1'b0, 4'h6);
        play(1'b0, 1'b0, 4'hE);
        step(0, 0, 0, 0, 0, 4'hE, 4'hE, "hold_errou");
        check_count("contaC_miss", n_cnt, 2);

        // Restart from errou, timeout (ignored by the TIMEOUT_EN=0 copy), collision.
        add(1, 0, 0, 0, 0, 4'h1, 4'h1);
        add(0, 0, 0, 0, 0, 4'h2, 4'h2);
        add(0, 0, 0, 0, 1, 4'hD, 4'h2);
        add(0, 0, 0, 0, 0, 4'hD, 4'h2);
        add(1, 0, 0, 0, 0, 4'h1, 4'h2);
        add(0, 0, 0, 0, 0, 4'h2, 4'h2);
        add(1, 0, 0, 0, 0, 4'h2, 4'h2);
        add(0, 1, 0, 0, 1, 4'h4, 4'h4);
        run_table("timeout");

        // Asynchronous reset while in registra.
        @(negedge clock);
        jogada_feita = 1'b0; timeout = 1'b0;
        reset = 1'b0;
        #1;
        check_dut("async_rst_en", st_a, outs_a, 4'h0);
        check_dut("async_rst_nt", st_b, outs_b, 4'h0);
        reset = 1'b1;

        // Plays outside espera_jogada are dropped, not queued.
        add(1, 1, 0, 0, 0, 4'h1, 4'h1);
        add(0, 1, 0, 0, 0, 4'h2, 4'h2);
        add(0, 0, 0, 0, 0, 4'h2, 4'h2);
        run_table("no_queue");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
